i2c_master: RTL and testbench
=============================

// Module: i2c_master
// PURPOSE
//   Single-byte I2C bus master: on request it issues START, 7-bit address + R/W, then one
//   data byte (write from din, or read into dout), then STOP. Drives open-drain SDA/SCL.
//   Sits between a system-clock command interface and the external I2C bus.
// PARAMETERS
//   SYS_FREQ  50_000_000  system clock frequency, Hz
//   I2C_FREQ  100_000     SCL frequency, Hz; SCL period = SYS_FREQ/I2C_FREQ = 500 clk
// PORTS
//   clk        in   1  system clock, all logic on rising edge
//   rst        in   1  asynchronous active-low reset
//   rw         in   1  1 = read, 0 = write
//   dataValid  in   1  request; sampled only in IDLE
//   addr       in   7  slave address
//   din        in   8  write data
//   dout       out  8  read data, valid when done pulses after a read
//   busy       out  1  high from request accept until done
//   ackErr     out  1  high when slave NACKs address or write data
//   done       out  1  one-clk pulse at end of transaction
//   sda        inout 1 open-drain: drive 0 or release (z); external pull-up
//   scl        inout 1 open-drain: drive 0 or release (z)
// BEHAVIOUR
// - Reset (rst=0, async): sda/scl released, dout=0, busy=0, ackErr=0, done=0, state IDLE.
//   Reset mid-transaction aborts immediately; no STOP is generated.
// - Bit timing: Q = SYS_FREQ/(4*I2C_FREQ) = 125 clk. Each bit = 4 quarters:
//   q0 SCL low, SDA updated; q1,q2 SCL high, SDA sampled at end of q1; q3 SCL low.
// - States: IDLE -> START -> ADDR(8 bits) -> ADDR_ACK -> WR_DATA | RD_DATA ->
//   WR_ACK | M_NACK -> STOP -> IDLE.
// - IDLE: lines released. dataValid=1 -> latch addr, rw, din; busy=1; clear ackErr;
//   go to START next clk. IDLE lasts >= 1 bit period (bus free time) after a STOP.
// - START (1 bit period): SDA falls while SCL high (q1), then SCL low.
// - ADDR: send {addr,rw} MSB first, 8 bits.
// - ADDR_ACK: release SDA, sample. 0 = ACK; 1 or z = NACK -> ackErr=1, go to STOP.
// - WR_DATA: din MSB first; WR_ACK as ADDR_ACK (NACK sets ackErr); then STOP.
// - RD_DATA: SDA released, 8 bits shifted in MSB first; dout loaded after 8th bit.
//   M_NACK: master releases SDA (NACK) for single-byte read, then STOP.
// - STOP (1 bit period): SDA low with SCL low, SCL rises, SDA rises while SCL high.
//   At end: done=1 for one clk, busy=0, ackErr held until next accept.
// - Full write = 20 bit periods = 10_000 clk at defaults.
// - dataValid held high: next transaction starts after the IDLE gap; changes to inputs
//   during busy are ignored.
// CONFIGURATION
// - I2C_CLK_STRETCH_EN defined: when master releases SCL and SCL still reads 0, the
//   quarter counter freezes until SCL reads 1 (slave clock stretching).
// - Not defined: SCL is not read back; timing is fixed at 4*Q per bit.
// TESTING
// 1. Hold rst=0 500 clk -> sda/scl z, busy=0, done=0, ackErr=0, dout=0.
// 2. Write addr=7'h55, din=8'h2F, rw=0, ACKing slave -> SDA bits 1010_1010, ACK, 0010_1111,
//    ACK, STOP; done pulse ~10_000 clk after accept; ackErr=0.
// 3. Same write, no slave (pull-up only) -> NACK at ADDR_ACK, ackErr=1, STOP, done pulse,
//    no data bits clocked.
// 4. Read rw=1 addr=7'h50, slave returns 8'hA5 -> dout=8'hA5 at done, master NACKs, STOP.
// 5. Assert rst=0 during ADDR bit 4 -> lines released within 1 clk, busy=0, IDLE.
// 6. With I2C_CLK_STRETCH_EN, slave holds SCL low 300 clk after ADDR_ACK -> transfer
//    resumes, total duration +300 clk.

Source files
------------

// File: rtl/i2c_master_if.sv
// Command-side interface of the single-byte I2C master: request, address/data in, result out.
// Modport "slave" is taken by i2c_master; modport "master" is for the issuing host.
interface i2c_master_if;
   logic       rw;
   logic       dataValid;
   logic [6:0] addr;
   logic [7:0] din;
   logic [7:0] dout;
   logic       busy;
   logic       ackErr;
   logic       done;

   modport master (output rw, dataValid, addr, din, input dout, busy, ackErr, done);
   modport slave  (input rw, dataValid, addr, din, output dout, busy, ackErr, done);
endinterface

// File: rtl/i2c_master.sv
// Single-byte I2C master: START, {addr,rw}, one data byte, STOP on open-drain SDA/SCL.
// Optional slave clock stretching is enabled by defining I2C_CLK_STRETCH_EN.
module i2c_master #(
   parameter int unsigned SYS_FREQ = 50_000_000,
   parameter int unsigned I2C_FREQ = 100_000
) (
   input  logic          clk,
   input  logic          rst,
   i2c_master_if.slave   bus,
   inout  wire           sda,
   inout  wire           scl
);

   localparam int unsigned Q   = SYS_FREQ / (4 * I2C_FREQ);
   localparam int unsigned QW  = (Q > 1) ? $clog2(Q) : 1;
   localparam int unsigned GAP = 4 * Q;
   localparam int unsigned GW  = $clog2(GAP + 1);

   typedef enum logic [3:0] {
      IDLE, START, ADDR, ADDR_ACK, WR_DATA, RD_DATA, WR_ACK, M_NACK, STOP
   } state_e;

   state_e          state_q, state_d;
   logic [QW-1:0]   qcnt_q, qcnt_d;
   logic [1:0]      phase_q, phase_d;
   logic [2:0]      bitcnt_q, bitcnt_d;
   logic [GW-1:0]   gap_q, gap_d;
   logic [6:0]      addr_q, addr_d;
   logic            rw_q, rw_d;
   logic [7:0]      din_q, din_d;
   logic [7:0]      rx_q, rx_d;
   logic [7:0]      dout_q, dout_d;
   logic            busy_q, busy_d;
   logic            ack_err_q, ack_err_d;
   logic            done_q, done_d;
   logic            sda_low_q, sda_low_d;
   logic            scl_low_q, scl_low_d;
   logic            sda_s1_q, sda_s2_q;
   logic            stall, tick, sample, bit_end;
   logic [7:0]      abyte;
`ifdef I2C_CLK_STRETCH_EN
   logic            scl_s1_q, scl_s2_q;
`endif

   assign sda = sda_low_q ? 1'b0 : 1'bz;
   assign scl = scl_low_q ? 1'b0 : 1'bz;

   assign bus.dout   = dout_q;
   assign bus.busy   = busy_q;
   assign bus.ackErr = ack_err_q;
   assign bus.done   = done_q;

   always_comb begin
      state_d   = state_q;
      qcnt_d    = qcnt_q;
      phase_d   = phase_q;
      bitcnt_d  = bitcnt_q;
      gap_d     = gap_q;
      addr_d    = addr_q;
      rw_d      = rw_q;
      din_d     = din_q;
      rx_d      = rx_q;
      dout_d    = dout_q;
      busy_d    = busy_q;
      ack_err_d = ack_err_q;
      done_d    = 1'b0;
      stall     = 1'b0;
      tick      = 1'b0;
      bit_end   = 1'b0;
      abyte     = {addr_q, rw_q};
`ifdef I2C_CLK_STRETCH_EN
      // SCL released by us but still held low elsewhere: freeze the quarter timer
      stall = (state_q != IDLE) && !scl_low_q && !scl_s2_q;
`endif
      if (state_q != IDLE && !stall) begin
         if (qcnt_q == QW'(Q - 1)) begin
            qcnt_d  = '0;
            tick    = 1'b1;
            phase_d = phase_q + 2'd1;
            bit_end = (phase_q == 2'd3);
         end else begin
            qcnt_d = qcnt_q + 1'b1;
         end
      end
      sample = tick && (phase_q == 2'd1);

      unique case (state_q)
         IDLE: begin
            if (gap_q != '0) begin
               gap_d = gap_q - 1'b1;
            end else if (bus.dataValid) begin
               addr_d    = bus.addr;
               rw_d      = bus.rw;
               din_d     = bus.din;
               busy_d    = 1'b1;
               ack_err_d = 1'b0;
               qcnt_d    = '0;
               phase_d   = '0;
               state_d   = START;
            end
         end
         START: if (bit_end) begin
            bitcnt_d = '0;
            state_d  = ADDR;
         end
         ADDR: if (bit_end) begin
            bitcnt_d = bitcnt_q + 3'd1;
            if (bitcnt_q == 3'd7) state_d = ADDR_ACK;
         end
         ADDR_ACK: begin
            if (sample && sda_s2_q) ack_err_d = 1'b1;
            if (bit_end) begin
               bitcnt_d = '0;
               if (ack_err_q)  state_d = STOP;
               else if (rw_q)  state_d = RD_DATA;
               else            state_d = WR_DATA;
            end
         end
         WR_DATA: if (bit_end) begin
            bitcnt_d = bitcnt_q + 3'd1;
            if (bitcnt_q == 3'd7) state_d = WR_ACK;
         end
         WR_ACK: begin
            if (sample && sda_s2_q) ack_err_d = 1'b1;
            if (bit_end) state_d = STOP;
         end
         RD_DATA: begin
            if (sample) rx_d = {rx_q[6:0], sda_s2_q};
            if (bit_end) begin
               bitcnt_d = bitcnt_q + 3'd1;
               if (bitcnt_q == 3'd7) begin
                  dout_d  = rx_q;
                  state_d = M_NACK;
               end
            end
         end
         M_NACK: if (bit_end) state_d = STOP;
         STOP: if (bit_end) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            gap_d   = GW'(GAP);
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Line drive is derived from the next-state view so pins change on the same edge as the phase
      sda_low_d = 1'b0;
      scl_low_d = 1'b0;
      unique case (state_d)
         START: begin
            sda_low_d = (phase_d != 2'd0);
            scl_low_d = (phase_d == 2'd3);
         end
         ADDR: begin
            sda_low_d = !abyte[3'd7 - bitcnt_d];
            scl_low_d = (phase_d == 2'd0) || (phase_d == 2'd3);
         end
         WR_DATA: begin
            sda_low_d = !din_q[3'd7 - bitcnt_d];
            scl_low_d = (phase_d == 2'd0) || (phase_d == 2'd3);
         end
         ADDR_ACK, WR_ACK, RD_DATA, M_NACK: begin
            scl_low_d = (phase_d == 2'd0) || (phase_d == 2'd3);
         end
         STOP: begin
            sda_low_d = (phase_d <= 2'd1);
            scl_low_d = (phase_d == 2'd0);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         qcnt_q    <= '0;
         phase_q   <= '0;
         bitcnt_q  <= '0;
         gap_q     <= '0;
         addr_q    <= '0;
         rw_q      <= 1'b0;
         din_q     <= '0;
         rx_q      <= '0;
         dout_q    <= '0;
         busy_q    <= 1'b0;
         ack_err_q <= 1'b0;
         done_q    <= 1'b0;
         sda_low_q <= 1'b0;
         scl_low_q <= 1'b0;
         sda_s1_q  <= 1'b1;
         sda_s2_q  <= 1'b1;
`ifdef I2C_CLK_STRETCH_EN
         scl_s1_q  <= 1'b1;
         scl_s2_q  <= 1'b1;
`endif
      end else begin
         state_q   <= state_d;
         qcnt_q    <= qcnt_d;
         phase_q   <= phase_d;
         bitcnt_q  <= bitcnt_d;
         gap_q     <= gap_d;
         addr_q    <= addr_d;
         rw_q      <= rw_d;
         din_q     <= din_d;
         rx_q      <= rx_d;
         dout_q    <= dout_d;
         busy_q    <= busy_d;
         ack_err_q <= ack_err_d;
         done_q    <= done_d;
         sda_low_q <= sda_low_d;
         scl_low_q <= scl_low_d;
         sda_s1_q  <= sda;
         sda_s2_q  <= sda_s1_q;
`ifdef I2C_CLK_STRETCH_EN
         scl_s1_q  <= scl;
         scl_s2_q  <= scl_s1_q;
`endif
      end
   end

endmodule

// File: tb/tb_i2c_master.sv
// Directed + randomized bench for i2c_master with a bus-level slave model on the open-drain lines.
// Expected SDA bit streams, latencies and flags are computed from the I2C framing rules.
module tb_i2c_master;

   localparam int unsigned SYS_F = 4_000_000;
   localparam int unsigned I2C_F = 100_000;
   localparam int unsigned BIT   = 4 * (SYS_F / (4 * I2C_F));

   logic clk = 1'b0;
   logic rst = 1'b0;
   wire  sda, scl;

   i2c_master_if bus_if ();

   i2c_master #(.SYS_FREQ(SYS_F), .I2C_FREQ(I2C_F)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if),
      .sda (sda),
      .scl (scl)
   );

   pullup (sda);
   pullup (scl);

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Bus-level slave: samples SDA on every SCL rise, answers ACK/read data while SCL is low
   logic       slv_low = 1'b0;
   logic       addr_ack_en = 1'b1;
   logic       data_ack_en = 1'b1;
   logic [7:0] rd_byte = '0;
   logic       bits[$];
   int         nbits = 0;
   int         starts = 0;
   int         stops = 0;
   logic       scl_p = 1'b1;
   logic       sda_p = 1'b1;

   assign sda = slv_low ? 1'b0 : 1'bz;

   always @(negedge clk) begin
      if (scl_p && scl && sda_p && !sda) begin
         starts++;
         nbits = 0;
         bits.delete();
      end
      if (scl_p && scl && !sda_p && sda) stops++;
      if (!scl_p && scl) begin
         bits.push_back(sda);
         nbits++;
      end
      if (scl_p && !scl) begin
         if (nbits == 8)
            slv_low = addr_ack_en;
         else if (nbits >= 9 && nbits <= 16 && bits.size() >= 8 && bits[7] && addr_ack_en)
            slv_low = !rd_byte[16 - nbits];
         else if (nbits == 17 && bits.size() >= 8 && !bits[7] && data_ack_en)
            slv_low = 1'b1;
         else
            slv_low = 1'b0;
      end
      scl_p = scl;
      sda_p = sda;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   logic [7:0] dout_model = '0;

   task automatic wait_busy(output int n);
      n = 0;
      while (bus_if.busy !== 1'b1 && n < 8 * BIT) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic wait_done(output int n);
      n = 0;
      while (bus_if.done !== 1'b1 && n < 30 * BIT) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic run_txn(input logic [6:0] a, input logic [7:0] d, input logic r,
                          input logic aack, input logic dack, input bit hold);
      int         n;
      logic       exp_q[$];
      logic [7:0] ab;
      logic [31:0] ov, ev;
      logic       exp_err;
      int         nbit;
      addr_ack_en = aack;
      data_ack_en = dack;
      starts = 0;
      stops  = 0;
      @(negedge clk);
      bus_if.addr = a;
      bus_if.din  = d;
      bus_if.rw   = r;
      bus_if.dataValid = 1'b1;
      wait_busy(n);
      check("accept", {31'd0, bus_if.busy}, 32'd1);
      if (!hold) begin
         bus_if.dataValid = 1'b0;
         bus_if.addr = 7'($urandom);
         bus_if.din  = 8'($urandom);
         bus_if.rw   = 1'($urandom);
      end
      wait_done(n);

      ab = {a, r};
      for (int i = 7; i >= 0; i--) exp_q.push_back(ab[i]);
      exp_q.push_back(!aack);
      if (aack) begin
         for (int i = 7; i >= 0; i--) exp_q.push_back(r ? rd_byte[i] : d[i]);
         exp_q.push_back(r ? 1'b1 : !dack);
      end
      exp_q.push_back(1'b0);
      exp_err = !aack || (!r && !dack);
      nbit    = aack ? 20 : 11;
      if (r && aack) dout_model = rd_byte;

      check("latency", n, nbit * BIT);
      check("ackErr", {31'd0, bus_if.ackErr}, {31'd0, exp_err});
      check("busy_at_done", {31'd0, bus_if.busy}, 32'd0);
      check("dout", {24'd0, bus_if.dout}, {24'd0, dout_model});
      check("scl_rises", bits.size(), exp_q.size());
      ov = '0;
      ev = '0;
      foreach (bits[i])  ov = {ov[30:0], bits[i]};
      foreach (exp_q[i]) ev = {ev[30:0], exp_q[i]};
      check("sda_bits", ov, ev);
      check("start_cnt", starts, 1);
      check("stop_cnt", stops, 1);
      @(negedge clk);
      check("done_pulse", {31'd0, bus_if.done}, 32'd0);
   endtask

   initial begin
      int n;
      #(20 * BIT * 10 * 40);
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      logic [6:0] ra;
      logic [7:0] rd;
      logic       rr, aa, da;
      bus_if.rw = 1'b0;
      bus_if.dataValid = 1'b0;
      bus_if.addr = '0;
      bus_if.din  = '0;

      repeat (500) @(negedge clk);
      check("rst_sda", {31'd0, sda}, 32'd1);
      check("rst_scl", {31'd0, scl}, 32'd1);
      check("rst_busy", {31'd0, bus_if.busy}, 32'd0);
      check("rst_done", {31'd0, bus_if.done}, 32'd0);
      check("rst_ackErr", {31'd0, bus_if.ackErr}, 32'd0);
      check("rst_dout", {24'd0, bus_if.dout}, 32'd0);
      rst = 1'b1;
      repeat (5) @(negedge clk);

      run_txn(7'h55, 8'h2F, 1'b0, 1'b1, 1'b1, 1'b0);
      run_txn(7'h55, 8'h2F, 1'b0, 1'b0, 1'b0, 1'b0);
      rd_byte = 8'hA5;
      run_txn(7'h50, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0);
      run_txn(7'h12, 8'hC3, 1'b0, 1'b1, 1'b0, 1'b0);
      run_txn(7'h7F, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);

      for (int k = 0; k < 6; k++) begin
         ra = 7'($urandom);
         rd = 8'($urandom);
         rr = 1'($urandom);
         aa = ($urandom_range(0, 3) != 0);
         da = ($urandom_range(0, 3) != 0);
         rd_byte = 8'($urandom);
         run_txn(ra, rd, rr, aa, da, 1'b0);
      end

      // dataValid held high: the next transaction must wait out the bus free time
      run_txn(7'h3C, 8'h81, 1'b0, 1'b1, 1'b1, 1'b1);
      wait_busy(n);
      check("bus_free", {31'd0, (n + 1 >= int'(BIT)) && (n < 8 * int'(BIT))}, 32'd1);
      bus_if.dataValid = 1'b0;
      wait_done(n);
      check("latency_held", n, 20 * BIT);
      @(negedge clk);

      // reset in the middle of address bit 4
      addr_ack_en = 1'b1;
      starts = 0;
      @(negedge clk);
      bus_if.addr = 7'h2A;
      bus_if.din  = 8'h66;
      bus_if.rw   = 1'b0;
      bus_if.dataValid = 1'b1;
      wait_busy(n);
      bus_if.dataValid = 1'b0;
      n = 0;
      while (!(starts == 1 && nbits == 4 && scl === 1'b0) && n < 30 * BIT) begin
         @(negedge clk);
         n++;
      end
      check("reach_addr_bit4", {31'd0, n < 30 * int'(BIT)}, 32'd1);
      rst = 1'b0;
      #1;
      check("abort_sda", {31'd0, sda}, 32'd1);
      check("abort_scl", {31'd0, scl}, 32'd1);
      check("abort_busy", {31'd0, bus_if.busy}, 32'd0);
      check("abort_done", {31'd0, bus_if.done}, 32'd0);
      dout_model = '0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("post_abort_idle", {31'd0, bus_if.busy}, 32'd0);

      rd_byte = 8'h5A;
      run_txn(7'h50, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
